// File: rtl/aes_round_engine_scheduler_if.sv
// rtl/aes_round_engine_scheduler_if.sv - request, engine and result signals of the round engine scheduler
interface aes_round_engine_scheduler_if #(
  parameter int N_REQ    = 4,
  parameter int NB_STATE = 128,
  parameter int NB_ID    = 2
);
  logic [N_REQ-1:0]          i_req_valid;
  logic [N_REQ-1:0]          o_req_ready;
  logic [N_REQ*NB_STATE-1:0] i_req_state;
  logic [N_REQ*NB_STATE-1:0] i_req_data;
  logic                      o_eng_trigger;
  logic                      o_eng_valid;
  logic [NB_STATE-1:0]       o_eng_state;
  logic [NB_STATE-1:0]       i_eng_state;
  logic                      o_out_valid;
  logic                      i_out_ready;
  logic [NB_STATE-1:0]       o_out_state;
  logic [NB_ID-1:0]          o_out_id;
  logic                      o_busy;

  modport slave (
    input  i_req_valid, i_req_state, i_req_data, i_eng_state, i_out_ready,
    output o_req_ready, o_eng_trigger, o_eng_valid, o_eng_state,
    output o_out_valid, o_out_state, o_out_id, o_busy
  );

  modport master (
    output i_req_valid, i_req_state, i_req_data, i_eng_state, i_out_ready,
    input  o_req_ready, o_eng_trigger, o_eng_valid, o_eng_state,
    input  o_out_valid, o_out_state, o_out_id, o_busy
  );
endinterface

// File: rtl/aes_round_engine_scheduler.sv
// rtl/aes_round_engine_scheduler.sv - round-robin sharing of one iterative AES round engine
// One block in flight: grant, load the engine, step N_ROUNDS rounds, return cipher ^ data.
module aes_round_engine_scheduler #(
  parameter int NB_BYTE  = 8,
  parameter int N_BYTES  = 16,
  parameter int N_ROUNDS = 14,
  parameter int N_REQ    = 4,
  parameter int NB_ID    = 2
) (
  input logic i_clock,
  input logic i_reset,
  aes_round_engine_scheduler_if.slave bus
);
  localparam int NB_STATE = N_BYTES * NB_BYTE;
  localparam int NB_CAND  = NB_ID + 1;
  localparam logic [3:0]       RND_LAST = 4'(N_ROUNDS);
  localparam logic [NB_ID-1:0] ID_LAST  = NB_ID'(N_REQ - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t              state_q, state_d;
  logic [3:0]          rnd_cnt_q;
  logic [NB_ID-1:0]    rr_ptr_q;
  logic [NB_ID-1:0]    id_q;
  logic [NB_ID-1:0]    out_id_q;
  logic [NB_ID-1:0]    grant_idx;
  logic [NB_STATE-1:0] data_q;
  logic [NB_STATE-1:0] out_state_q;
  logic                grant_found;
  logic                accept;
  logic [NB_CAND-1:0]  cand;
  logic [N_REQ-1:0]    req_ready;

  logic [NB_STATE-1:0] req_state_a [N_REQ];
  logic [NB_STATE-1:0] req_data_a  [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign req_state_a[k] = bus.i_req_state[k*NB_STATE +: NB_STATE];
    assign req_data_a[k]  = bus.i_req_data[k*NB_STATE +: NB_STATE];
  end

  // First valid requester at or after rr_ptr, wrapping at N_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + NB_CAND'(i);
      if (cand >= NB_CAND'(N_REQ)) begin
        cand = cand - NB_CAND'(N_REQ);
      end
      if (!grant_found && bus.i_req_valid[cand[NB_ID-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[NB_ID-1:0];
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    accept            = 1'b0;
    req_ready         = '0;
    bus.o_eng_trigger = 1'b0;
    bus.o_eng_valid   = 1'b0;
    bus.o_eng_state   = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_found && !i_reset) begin
          req_ready[grant_idx] = 1'b1;
          bus.o_eng_trigger    = 1'b1;
          bus.o_eng_valid      = 1'b1;
          bus.o_eng_state      = req_state_a[grant_idx];
          accept               = 1'b1;
          state_d              = ST_RUN;
        end
      end
      ST_RUN: begin
        bus.o_eng_valid = !i_reset;
        if (rnd_cnt_q == RND_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.i_out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The engine's last-round output is only valid in the final RUN cycle, so capture it there.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      rnd_cnt_q   <= '0;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      data_q      <= '0;
      out_state_q <= '0;
      out_id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q    <= req_data_a[grant_idx];
        id_q      <= grant_idx;
        rnd_cnt_q <= 4'd1;
        rr_ptr_q  <= (grant_idx == ID_LAST) ? '0 : grant_idx + NB_ID'(1);
      end else if (state_q == ST_RUN) begin
        if (rnd_cnt_q == RND_LAST) begin
          out_state_q <= bus.i_eng_state ^ data_q;
          out_id_q    <= id_q;
          rnd_cnt_q   <= '0;
        end else begin
          rnd_cnt_q <= rnd_cnt_q + 4'd1;
        end
      end
    end
  end

  assign bus.o_req_ready = req_ready;
  assign bus.o_out_valid = (state_q == ST_DONE);
  assign bus.o_out_state = out_state_q;
  assign bus.o_out_id    = out_id_q;
  assign bus.o_busy      = (state_q != ST_IDLE);
endmodule
